move_sequencer: RTL and testbench

Turn-owning front end for move checking in the game-play path. It holds the authoritative 8x8 board and the side-to-move, and turns cursor selections into move requests for the combinational move validator. It commits accepted moves, including capture, pawn promotion and game-over, and reports rejected moves.

---
 rtl/move_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Turn-owning front end for move checking: holds the committed board and side-to-move,
// turns cursor selections into validator requests and commits accepted moves.
module move_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sel_valid,
    input  logic [2:0]            sel_x,
    input  logic [2:0]            sel_y,
    input  logic                  cancel,
    output logic                  req_valid,
    output logic [2:0]            req_old_x,
    output logic [2:0]            req_old_y,
    output logic [2:0]            req_new_x,
    output logic [2:0]            req_new_y,
    output logic [3:0]            req_piece,
    output logic [7:0][7:0][3:0]  req_board,
    input  logic                  rsp_valid_move,
    input  logic                  rsp_valid,
    output logic [7:0][7:0][3:0]  board_out,
    output logic                  turn,
    output logic                  sel_active,
    output logic [2:0]            src_x,
    output logic [2:0]            src_y,
    output logic                  move_done,
    output logic                  move_rejected,
    output logic [3:0]            captured_piece,
    output logic                  game_over
);
    typedef logic [7:0][7:0][3:0] board_t;
    typedef enum logic [2:0] {IDLE, SRC, REQ, COMMIT, OVER} state_t;

    function automatic logic [3:0] back_rank(input int c);
        case (c)
            0, 7:    return 4'd0;
            1, 6:    return 4'd1;
            2, 5:    return 4'd2;
            3:       return 4'd3;
            default: return 4'd4;
        endcase
    endfunction

    function automatic board_t init_board();
        board_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 4'hF;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = back_rank(c);
            b[1][c] = 4'd5;
            b[6][c] = 4'd11;
            b[7][c] = back_rank(c) + 4'd6;
        end
        return b;
    endfunction

    localparam board_t INIT_BOARD = init_board();

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic       turn_q, turn_d, sel_active_q, sel_active_d;
    logic [2:0] src_x_q, src_x_d, src_y_q, src_y_d, dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [3:0] cnt_q, cnt_d;
    logic       req_valid_q, req_valid_d;
    logic [2:0] req_old_x_q, req_old_x_d, req_old_y_q, req_old_y_d;
    logic [2:0] req_new_x_q, req_new_x_d, req_new_y_q, req_new_y_d;
    logic [3:0] req_piece_q, req_piece_d;
    logic       move_done_q, move_done_d, move_rejected_q, move_rejected_d;
    logic [3:0] captured_q, captured_d;
    logic       game_over_q, game_over_d;

    logic [3:0] sel_piece, src_piece, dst_piece, land_piece;
    logic       sel_own;

    always_comb begin
        sel_piece  = board_q[sel_y][sel_x];
        src_piece  = board_q[src_y_q][src_x_q];
        dst_piece  = board_q[dst_y_q][dst_x_q];
        sel_own    = turn_q ? (sel_piece <= 4'd5) : (sel_piece >= 4'd6 && sel_piece <= 4'd11);
        land_piece = src_piece;
        if (src_piece == 4'd11 && dst_y_q == 3'd0) land_piece = 4'd9;
        if (src_piece == 4'd5  && dst_y_q == 3'd7) land_piece = 4'd3;

        state_d         = state_q;
        board_d         = board_q;
        turn_d          = turn_q;
        sel_active_d    = sel_active_q;
        src_x_d         = src_x_q;
        src_y_d         = src_y_q;
        dst_x_d         = dst_x_q;
        dst_y_d         = dst_y_q;
        cnt_d           = cnt_q;
        req_valid_d     = req_valid_q;
        req_old_x_d     = req_old_x_q;
        req_old_y_d     = req_old_y_q;
        req_new_x_d     = req_new_x_q;
        req_new_y_d     = req_new_y_q;
        req_piece_d     = req_piece_q;
        move_done_d     = 1'b0;
        move_rejected_d = 1'b0;
        captured_d      = captured_q;
        game_over_d     = game_over_q;

        case (state_q)
            IDLE: begin
                if (sel_valid && sel_own) begin
                    src_x_d      = sel_x;
                    src_y_d      = sel_y;
                    sel_active_d = 1'b1;
                    state_d      = SRC;
                end
            end
            SRC: begin
                if (cancel || (sel_valid && sel_x == src_x_q && sel_y == src_y_q)) begin
                    sel_active_d = 1'b0;
                    state_d      = IDLE;
                end else if (sel_valid && sel_own) begin
                    src_x_d = sel_x;
                    src_y_d = sel_y;
                end else if (sel_valid) begin
                    // Requests go out in the mover's frame so the validator sees one pawn direction.
                    dst_x_d     = sel_x;
                    dst_y_d     = sel_y;
                    cnt_d       = 4'd0;
                    req_valid_d = 1'b1;
                    req_old_x_d = src_x_q;
                    req_old_y_d = turn_q ? 3'd7 - src_y_q : src_y_q;
                    req_new_x_d = sel_x;
                    req_new_y_d = turn_q ? 3'd7 - sel_y : sel_y;
                    req_piece_d = src_piece;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (rsp_valid && rsp_valid_move) begin
                    req_valid_d = 1'b0;
                    state_d     = COMMIT;
                end else if (rsp_valid || cnt_q == 4'(TIMEOUT - 1)) begin
                    req_valid_d     = 1'b0;
                    move_rejected_d = 1'b1;
                    sel_active_d    = 1'b0;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            COMMIT: begin
                board_d[dst_y_q][dst_x_q] = land_piece;
                board_d[src_y_q][src_x_q] = 4'hF;
                captured_d   = dst_piece;
                turn_d       = ~turn_q;
                move_done_d  = 1'b1;
                sel_active_d = 1'b0;
                if (dst_piece == 4'd4 || dst_piece == 4'd10) begin
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else begin
                    state_d = IDLE;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            board_q         <= INIT_BOARD;
            turn_q          <= 1'b0;
            sel_active_q    <= 1'b0;
            src_x_q         <= 3'd0;
            src_y_q         <= 3'd0;
            dst_x_q         <= 3'd0;
            dst_y_q         <= 3'd0;
            cnt_q           <= 4'd0;
            req_valid_q     <= 1'b0;
            req_old_x_q     <= 3'd0;
            req_old_y_q     <= 3'd0;
            req_new_x_q     <= 3'd0;
            req_new_y_q     <= 3'd0;
            req_piece_q     <= 4'd0;
            move_done_q     <= 1'b0;
            move_rejected_q <= 1'b0;
            captured_q      <= 4'hF;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            turn_q          <= turn_d;
            sel_active_q    <= sel_active_d;
            src_x_q         <= src_x_d;
            src_y_q         <= src_y_d;
            dst_x_q         <= dst_x_d;
            dst_y_q         <= dst_y_d;
            cnt_q           <= cnt_d;
            req_valid_q     <= req_valid_d;
            req_old_x_q     <= req_old_x_d;
            req_old_y_q     <= req_old_y_d;
            req_new_x_q     <= req_new_x_d;
            req_new_y_q     <= req_new_y_d;
            req_piece_q     <= req_piece_d;
            move_done_q     <= move_done_d;
            move_rejected_q <= move_rejected_d;
            captured_q      <= captured_d;
            game_over_q     <= game_over_d;
        end
    end

    // Mirrored view is combinational; the board only moves in COMMIT so it holds through REQ.
    always_comb begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                req_board[r][c] = turn_q ? board_q[7-r][c] : board_q[r][c];
    end

    assign board_out      = board_q;
    assign turn           = turn_q;
    assign sel_active     = sel_active_q;
    assign src_x          = src_x_q;
    assign src_y          = src_y_q;
    assign req_valid      = req_valid_q;
    assign req_old_x      = req_old_x_q;
    assign req_old_y      = req_old_y_q;
    assign req_new_x      = req_new_x_q;
    assign req_new_y      = req_new_y_q;
    assign req_piece      = req_piece_q;
    assign move_done      = move_done_q;
    assign move_rejected  = move_rejected_q;
    assign captured_piece = captured_q;
    assign game_over      = game_over_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: scripted selections, hand-written expected boards.
module tb_move_sequencer;
    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 sel_valid, cancel, rsp_valid_move, rsp_valid;
    logic [2:0]           sel_x, sel_y;
    logic                 req_valid;
    logic [2:0]           req_old_x, req_old_y, req_new_x, req_new_y;
    logic [3:0]           req_piece;
    logic [7:0][7:0][3:0] req_board, board_out, exp_b;
    logic                 turn, sel_active, move_done, move_rejected, game_over;
    logic [2:0]           src_x, src_y;
    logic [3:0]           captured_piece;

    int n_checks = 0;
    int n_pass   = 0;

    move_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y),
        .cancel(cancel), .req_valid(req_valid), .req_old_x(req_old_x), .req_old_y(req_old_y),
        .req_new_x(req_new_x), .req_new_y(req_new_y), .req_piece(req_piece),
        .req_board(req_board), .rsp_valid_move(rsp_valid_move), .rsp_valid(rsp_valid),
        .board_out(board_out), .turn(turn), .sel_active(sel_active), .src_x(src_x),
        .src_y(src_y), .move_done(move_done), .move_rejected(move_rejected),
        .captured_piece(captured_piece), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic load_init();
        int rank0[8] = '{0, 1, 2, 3, 4, 2, 1, 0};
        int rank7[8] = '{6, 7, 8, 9, 10, 8, 7, 6};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_b[r][c] = 4'd15;
        for (int c = 0; c < 8; c++) begin
            exp_b[0][c] = 4'(rank0[c]);
            exp_b[1][c] = 4'd5;
            exp_b[6][c] = 4'd11;
            exp_b[7][c] = 4'(rank7[c]);
        end
    endtask

    // Returns 1ns after the edge that sampled the select.
    task automatic do_sel(input int x, input int y);
        @(negedge clk);
        sel_valid = 1'b1;
        sel_x = 3'(x);
        sel_y = 3'(y);
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
    endtask

    // Answer the pending request; returns 1ns after E1.
    task automatic answer(input logic ok);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_valid_move = ok;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_valid_move = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        sel_valid = 1'b0; cancel = 1'b0; rsp_valid = 1'b0; rsp_valid_move = 1'b0;
        sel_x = 3'd0; sel_y = 3'd0;
        load_init();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_board", board_out, exp_b);
        chk("rst_turn", turn, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_captured", captured_piece, 15);
        chk("rst_sel_active", sel_active, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Side 0: pawn (4,6) -> (4,4), accepted
        do_sel(4, 6);
        chk("t1_sel_active", sel_active, 1);
        chk("t1_src", {src_x, src_y}, {3'd4, 3'd6});
        do_sel(4, 4);
        chk("t1_req_valid_e0", req_valid, 1);
        chk("t1_req_coords", {req_old_x, req_old_y, req_new_x, req_new_y}, {3'd4, 3'd6, 3'd4, 3'd4});
        chk("t1_req_piece", req_piece, 11);
        answer(1'b1);
        chk("t1_done_e1", move_done, 0);
        chk("t1_board_e1", board_out, exp_b);
        @(posedge clk); #1;
        exp_b[4][4] = 4'd11;
        exp_b[6][4] = 4'd15;
        chk("t1_done_e2", move_done, 1);
        chk("t1_board_e2", board_out, exp_b);
        chk("t1_turn", turn, 1);
        chk("t1_captured", captured_piece, 15);
        chk("t1_sel_active", sel_active, 0);
        @(posedge clk); #1;
        chk("t1_done_once", move_done, 0);

        // Side 1: mirrored request, then rejected
        do_sel(4, 1);
        chk("t2_sel_active", sel_active, 1);
        do_sel(4, 3);
        chk("t2_req_old_y", req_old_y, 6);
        chk("t2_req_new_y", req_new_y, 4);
        chk("t2_req_x", {req_old_x, req_new_x}, {3'd4, 3'd4});
        chk("t2_req_piece", req_piece, 5);
        chk("t2_req_board_64", req_board[6][4], 5);
        chk("t2_req_board_00", req_board[0][0], 6);
        chk("t2_req_board_33", req_board[3][4], 11);
        answer(1'b0);
        chk("t2_rejected", move_rejected, 1);
        chk("t2_req_drop", req_valid, 0);
        chk("t2_no_done", move_done, 0);
        chk("t2_sel_active", sel_active, 0);
        @(posedge clk); #1;
        chk("t2_rejected_once", move_rejected, 0);
        chk("t2_board", board_out, exp_b);
        chk("t2_turn", turn, 1);

        // Timeout with no verdict
        do_sel(4, 1);
        do_sel(4, 3);
        chk("t3_req_valid", req_valid, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!move_rejected && n < 25);
        chk("t3_timeout_cycles", n, 15);
        chk("t3_req_drop", req_valid, 0);
        chk("t3_board", board_out, exp_b);

        // Cancel beats a same-cycle select
        do_sel(4, 1);
        chk("t4_sel_active", sel_active, 1);
        @(negedge clk);
        cancel = 1'b1; sel_valid = 1'b1; sel_x = 3'd4; sel_y = 3'd3;
        @(posedge clk); #1;
        cancel = 1'b0; sel_valid = 1'b0;
        chk("t4_cancel_sel", sel_active, 0);
        @(posedge clk); #1;
        chk("t4_no_req", req_valid, 0);

        // Side 1 quiet move back to side 0
        do_sel(0, 1);
        do_sel(0, 2);
        chk("t5_req_coords", {req_old_y, req_new_y}, {3'd6, 3'd5});
        answer(1'b1);
        @(posedge clk); #1;
        exp_b[2][0] = 4'd5;
        exp_b[1][0] = 4'd15;
        chk("t5_board", board_out, exp_b);
        chk("t5_turn", turn, 0);

        // Side 0 pawn lands on row 0 taking the king: promotion + game over
        do_sel(0, 6);
        do_sel(4, 0);
        chk("t6_req_new", {req_new_x, req_new_y}, {3'd4, 3'd0});
        answer(1'b1);
        @(posedge clk); #1;
        exp_b[0][4] = 4'd9;
        exp_b[6][0] = 4'd15;
        chk("t6_board", board_out, exp_b);
        chk("t6_captured", captured_piece, 4);
        chk("t6_game_over", game_over, 1);
        chk("t6_turn", turn, 1);
        do_sel(4, 1);
        chk("t6_sel_ignored", sel_active, 0);
        do_sel(4, 3);
        chk("t6_req_ignored", req_valid, 0);
        chk("t6_board_frozen", board_out, exp_b);

        // Async reset mid-REQ
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        load_init();
        chk("t7_rst_game_over", game_over, 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_sel(4, 6);
        do_sel(4, 4);
        chk("t7_in_req", req_valid, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_req_cleared", req_valid, 0);
        chk("t7_board", board_out, exp_b);
        chk("t7_turn", turn, 0);
        chk("t7_captured", captured_piece, 15);
        chk("t7_sel_active", sel_active, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t7_board_after", board_out, exp_b);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
